// File: rtl/icache_resp.sv
// icache_resp: direct-mapped read-only instruction cache answering core fetches,
// refilling whole lines from a word-wide backing memory
module icache_resp #(
    parameter int ADDR_W     = 32,
    parameter int INST_W     = 32,
    parameter int INDEX_BITS = 4,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              data_wen_i,
    input  logic              flush_i,
    output logic              data_valid_o,
    output logic [INST_W-1:0] data_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [INST_W-1:0] mem_data_i,
    output logic              busy_o
);
    localparam int WORD_BITS = $clog2(LINE_WORDS);
    localparam int OFF_BITS  = WORD_BITS + 2;
    localparam int TAG_W     = ADDR_W - INDEX_BITS - OFF_BITS;
    localparam int LINES     = 1 << INDEX_BITS;

    typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;
    state_t state, state_n;

    logic [LINES-1:0]      valid;
    logic [TAG_W-1:0]      tags  [LINES];
    logic [INST_W-1:0]     lines [LINES][LINE_WORDS];
    logic [ADDR_W-1:2]     req_addr;
    logic [WORD_BITS-1:0]  beat;
    logic                  flush_seen;
    logic [WORD_BITS-1:0]  in_word, r_word;
    logic [INDEX_BITS-1:0] in_idx, r_idx;
    logic [TAG_W-1:0]      in_tag, r_tag;
    logic                  hit, accept, last_ack, unused_addr;

    assign in_word     = addr_i[OFF_BITS-1:2];
    assign in_idx      = addr_i[OFF_BITS+INDEX_BITS-1:OFF_BITS];
    assign in_tag      = addr_i[ADDR_W-1:OFF_BITS+INDEX_BITS];
    assign r_word      = req_addr[OFF_BITS-1:2];
    assign r_idx       = req_addr[OFF_BITS+INDEX_BITS-1:OFF_BITS];
    assign r_tag       = req_addr[ADDR_W-1:OFF_BITS+INDEX_BITS];
    assign unused_addr = ^addr_i[1:0];

    // a flush on the request edge turns a would-be hit into a miss
    assign hit      = valid[in_idx] && tags[in_idx] == in_tag && !flush_i;
    assign accept   = state == IDLE && req_valid_i && !data_wen_i && !data_valid_o;
    assign last_ack = state == REFILL && mem_ack_i && beat == WORD_BITS'(LINE_WORDS - 1);
    assign busy_o   = state != IDLE;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (accept && !hit) state_n = REFILL;
        if (last_ack) state_n = RESP;
        if (state == RESP) state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (accept) req_addr <= addr_i[ADDR_W-1:2];
        if (state == REFILL && mem_ack_i) lines[r_idx][beat] <= mem_data_i;
        if (last_ack) tags[r_idx] <= r_tag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid        <= '0;
            data_valid_o <= 1'b0;
            data_o       <= '0;
            mem_req_o    <= 1'b0;
            mem_addr_o   <= '0;
            beat         <= '0;
            flush_seen   <= 1'b0;
        end else begin
            data_valid_o <= 1'b0;
            if (flush_i) valid <= '0;
            if (accept) begin
                flush_seen <= 1'b0;
                if (hit) begin
                    data_o       <= lines[in_idx][in_word];
                    data_valid_o <= 1'b1;
                end else begin
                    beat       <= '0;
                    mem_req_o  <= 1'b1;
                    mem_addr_o <= {addr_i[ADDR_W-1:OFF_BITS], {OFF_BITS{1'b0}}};
                end
            end
            // a flush seen anywhere in the refill keeps the new line invalid
            if (state == REFILL && flush_i) flush_seen <= 1'b1;
            if (state == REFILL && mem_ack_i) begin
                beat       <= beat + WORD_BITS'(1);
                mem_addr_o <= mem_addr_o + ADDR_W'(4);
            end
            if (last_ack) begin
                mem_req_o <= 1'b0;
                if (!flush_i && !flush_seen) valid[r_idx] <= 1'b1;
            end
            if (state == RESP) begin
                data_o       <= lines[r_idx][r_word];
                data_valid_o <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_icache_resp.sv
// tb_icache_resp: table-driven fetch sequences against a scoreboard of expected words,
// with a backing-memory responder that checks refill beat addresses
module tb_icache_resp;
    localparam int LINE_WORDS = 4;

    logic        clk, rst, req_valid_i, data_wen_i, flush_i;
    logic [31:0] addr_i;
    logic        data_valid_o, mem_req_o, mem_ack_i, busy_o;
    logic [31:0] data_o, mem_addr_o, mem_data_i;

    icache_resp #(.ADDR_W(32), .INST_W(32), .INDEX_BITS(4), .LINE_WORDS(LINE_WORDS)) dut (
        .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .addr_i(addr_i),
        .data_wen_i(data_wen_i), .flush_i(flush_i), .data_valid_o(data_valid_o),
        .data_o(data_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i), .busy_o(busy_o)
    );

    typedef struct {
        logic [31:0] addr;
        int          fc;
        bit          hit;
        logic [31:0] data;
    } vec_t;

    int          n_cmp = 0, n_fail = 0;
    int          ack_cnt = 0, ack_budget = 1000000;
    logic [31:0] exp_addr = 0;
    logic [31:0] sb[$];
    logic        prev_v = 0;
    vec_t        vecs[17];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (32'(a[3:2]) + 32'd1) * 32'h11 + 32'({a[15:4], 16'h0});
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        mem_ack_i = 0;
        mem_data_i = 0;
        forever begin
            @(negedge clk);
            if (mem_req_o === 1'b1 && ack_budget > 0) begin
                check("beat_addr", mem_addr_o, exp_addr);
                exp_addr += 4;
                ack_budget--;
                ack_cnt++;
                mem_ack_i = 1;
                mem_data_i = mem_word(mem_addr_o);
            end else begin
                mem_ack_i = 0;
                mem_data_i = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (data_valid_o === 1'b1) begin
            check("no_back_to_back", {31'b0, prev_v}, 0);
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_valid: got data %h expected no response", data_o);
            end else check("data", data_o, sb.pop_front());
        end
        prev_v = data_valid_o;
    end

    // fc: flush_i is high for the n-th edge after the request is driven (0 = never)
    task automatic fetch(input logic [31:0] a, input int fc, input bit h, input logic [31:0] d);
        int n, a0;
        @(negedge clk);
        @(negedge clk);
        exp_addr = a & 32'hFFFF_FFF0;
        a0 = ack_cnt;
        sb.push_back(d);
        req_valid_i = 1;
        addr_i = a;
        flush_i = (fc == 1);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            flush_i = (fc == n + 1);
        end while (data_valid_o !== 1'b1 && n < 50);
        req_valid_i = 0;
        flush_i = 0;
        check($sformatf("latency@%h", a), n, h ? 1 : LINE_WORDS + 2);
        check($sformatf("acks@%h", a), ack_cnt - a0, h ? 0 : LINE_WORDS);
    endtask

    initial begin
        int n, a0;
        vecs[0]  = '{32'h80000008, 0, 0, 32'h00000033};
        vecs[1]  = '{32'h8000000C, 0, 1, 32'h00000044};
        vecs[2]  = '{32'h80000108, 0, 0, 32'h00100033};
        vecs[3]  = '{32'h80000008, 0, 0, 32'h00000033};
        vecs[4]  = '{32'h80000014, 0, 0, 32'h00010022};
        vecs[5]  = '{32'h80000010, 0, 1, 32'h00010011};
        vecs[6]  = '{32'h80000000, 1, 0, 32'h00000011};
        vecs[7]  = '{32'h80000004, 0, 1, 32'h00000022};
        vecs[8]  = '{32'h8000001C, 0, 0, 32'h00010044};
        vecs[9]  = '{32'h80000028, 3, 0, 32'h00020033};
        vecs[10] = '{32'h80000028, 0, 0, 32'h00020033};
        vecs[11] = '{32'h8000002C, 0, 1, 32'h00020044};
        vecs[12] = '{32'h80000034, 5, 0, 32'h00030022};
        vecs[13] = '{32'h80000030, 0, 0, 32'h00030011};
        vecs[14] = '{32'h80000108, 0, 0, 32'h00100033};
        vecs[15] = '{32'h80000104, 0, 1, 32'h00100022};
        vecs[16] = '{32'h80000000, 0, 0, 32'h00000011};

        rst = 1;
        req_valid_i = 1;
        addr_i = 32'h80000008;
        data_wen_i = 0;
        flush_i = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'b0, data_valid_o}, 0);
        check("rst_data", data_o, 0);
        check("rst_mem_req", {31'b0, mem_req_o}, 0);
        check("rst_mem_addr", mem_addr_o, 0);
        check("rst_busy", {31'b0, busy_o}, 0);
        @(negedge clk);
        rst = 0;
        req_valid_i = 0;

        foreach (vecs[i]) fetch(vecs[i].addr, vecs[i].fc, vecs[i].hit, vecs[i].data);

        // back-to-back hits: the forced dead cycle spaces responses two cycles apart
        @(negedge clk);
        @(negedge clk);
        a0 = ack_cnt;
        sb.push_back(32'h11);
        sb.push_back(32'h22);
        req_valid_i = 1;
        addr_i = 32'h80000000;
        @(posedge clk);
        #1;
        check("thr_first", {31'b0, data_valid_o}, 1);
        addr_i = 32'h80000004;
        @(posedge clk);
        #1;
        check("thr_gap", {31'b0, data_valid_o}, 0);
        @(posedge clk);
        #1;
        check("thr_second", {31'b0, data_valid_o}, 1);
        req_valid_i = 0;
        check("thr_acks", ack_cnt - a0, 0);

        @(negedge clk);
        @(negedge clk);
        req_valid_i = 1;
        data_wen_i = 1;
        addr_i = 32'h80000000;
        repeat (10) begin
            @(posedge clk);
            #1;
            check("wen_valid", {31'b0, data_valid_o}, 0);
            check("wen_mem_req", {31'b0, mem_req_o}, 0);
        end
        req_valid_i = 0;
        data_wen_i = 0;

        @(negedge clk);
        @(negedge clk);
        ack_budget = 2;
        a0 = ack_cnt;
        exp_addr = 32'h80000040;
        req_valid_i = 1;
        addr_i = 32'h80000040;
        @(posedge clk);
        #1;
        req_valid_i = 0;
        n = 0;
        while (ack_cnt - a0 < 2 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("mid_acks", ack_cnt - a0, 2);
        check("mid_req_held", {31'b0, mem_req_o}, 1);
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
        check("mid_rst_req", {31'b0, mem_req_o}, 0);
        check("mid_rst_busy", {31'b0, busy_o}, 0);
        check("mid_rst_valid", {31'b0, data_valid_o}, 0);
        @(negedge clk);
        rst = 0;
        ack_budget = 1000000;
        fetch(32'h80000000, 0, 0, 32'h00000011);
        fetch(32'h80000040, 0, 0, 32'h00040011);

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
